// File: rtl/pwm_config_controller_if.sv
// rtl/pwm_config_controller_if.sv - SPI pins and PWM channel signals of the PWM config controller
interface pwm_config_controller_if;
  logic        _CS;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [3:0]  PeriodEnd;
  logic [31:0] DutyOut;
  logic [3:0]  EnableOut;
  logic [3:0]  Pending;

  modport slave (
    input  _CS, SCLK, MOSI, PeriodEnd,
    output MISO, DutyOut, EnableOut, Pending
  );

  modport master (
    output _CS, SCLK, MOSI, PeriodEnd,
    input  MISO, DutyOut, EnableOut, Pending
  );
endinterface

// File: rtl/pwm_config_controller.sv
// rtl/pwm_config_controller.sv - SPI command decoder and shadowed duty register file for four PWM channels
module pwm_config_controller #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUTY_RESET  = 8'h00
) (
  input logic                     CLK,
  input logic                     _RST,
  pwm_config_controller_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // _CS and SCLK carry one extra stage so the last two synchronized samples can be compared
  logic [SYNC_STAGES:0]   cs_sr;
  logic [SYNC_STAGES:0]   sclk_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       rw_q;
  logic [3:0] addr_q;
  logic [7:0] miso_sr;
  logic       wr_pend;
  logic [7:0] wr_data;
  logic [3:0] cmd_addr;
  logic [7:0] rd_val;

  logic [7:0] shadow [4];
  logic [7:0] active [4];
  logic [3:0] pend;
  logic [3:0] en;

  // Input synchronizers; idle values keep a reset from looking like a _CS fall or SCLK edge
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      cs_sr   <= '1;
      sclk_sr <= '0;
      mosi_sr <= '0;
    end else begin
      cs_sr   <= {cs_sr[SYNC_STAGES-1:0], bus._CS};
      sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], bus.SCLK};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], bus.MOSI};
    end
  end

  assign cs_fall   = !cs_sr[SYNC_STAGES-1] &&  cs_sr[SYNC_STAGES];
  assign cs_rise   =  cs_sr[SYNC_STAGES-1] && !cs_sr[SYNC_STAGES];
  assign sclk_rise =  sclk_sr[SYNC_STAGES-1] && !sclk_sr[SYNC_STAGES];
  assign sclk_fall = !sclk_sr[SYNC_STAGES-1] &&  sclk_sr[SYNC_STAGES];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];

  // Address being completed by the 8th rise; the read value is captured from it at that moment
  assign cmd_addr = {shift[2:0], mosi_s};

  // Read mux over the register map; duty addresses return the shadow copy
  always_comb begin
    rd_val = 8'h00;
    case (cmd_addr)
      4'd0, 4'd1, 4'd2, 4'd3: rd_val = shadow[cmd_addr[1:0]];
      4'd4:                   rd_val = {4'b0000, en};
      4'd5:                   rd_val = {4'b0000, pend};
      default:                rd_val = 8'h00;
    endcase
  end

  // Frame decoder; the first fall after the command byte is skipped so bit 7 is still on MISO at rise 9
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift   <= 7'd0;
      rw_q    <= 1'b0;
      addr_q  <= 4'd0;
      miso_sr <= 8'd0;
      wr_pend <= 1'b0;
      wr_data <= 8'd0;
    end else begin
      wr_pend <= 1'b0;
      if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift   <= {shift[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw_q    <= shift[6];
                addr_q  <= cmd_addr;
                miso_sr <= rd_val;
                state   <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift   <= {shift[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                wr_pend <= rw_q;
                wr_data <= {shift, mosi_s};
                state   <= DONE;
              end
            end else if (sclk_fall && bit_cnt != 3'd0) begin
              miso_sr <= {miso_sr[6:0], 1'b0};
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Register file: a write and a period boundary in the same cycle transfer the old shadow and keep Pending set
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      for (int n = 0; n < 4; n++) begin
        shadow[n] <= DUTY_RESET;
        active[n] <= DUTY_RESET;
      end
      pend <= 4'd0;
      en   <= 4'd0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (bus.PeriodEnd[n] && pend[n]) begin
          active[n] <= shadow[n];
        end
        if (wr_pend && addr_q == 4'(n)) begin
          shadow[n] <= wr_data;
          pend[n]   <= 1'b1;
        end else if (bus.PeriodEnd[n] && pend[n]) begin
          pend[n] <= 1'b0;
        end
      end
      if (wr_pend && addr_q == 4'd4) begin
        en <= wr_data[3:0];
      end
    end
  end

  assign bus.MISO      = (state == DATA && !rw_q) ? miso_sr[7] : 1'b0;
  assign bus.DutyOut   = {active[3], active[2], active[1], active[0]};
  assign bus.EnableOut = en;
  assign bus.Pending   = pend;

endmodule
